rr_arb8: RTL and testbench

RR_ARB8 -- requirements
Module: rr_arb8

---
 rtl/rr_arb8.sv | 140 ++++++++++++++
 tb/tb_rr_arb8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb8 : 8-way round-robin arbiter with hold limit and forced rotation
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb8 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] hcnt_q, hcnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;

  logic       do_grant;
  logic [7:0] cand;
  logic [2:0] win;

  // Descending search starting at p, wrapping 0 -> 7; first set bit wins.
  function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] p);
    logic [2:0] r;
    logic [2:0] i;
    logic       f;
    r = p;
    f = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i = p - 3'(k);
      if (!f && c[i]) begin
        r = i;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    do_grant    = 1'b0;
    cand        = 8'h00;
    win         = 3'd0;

    case (state_q)
      IDLE: begin
        if (en && (|req)) begin
          do_grant = 1'b1;
          cand     = req;
        end
      end
      GRANT: begin
        if (!en) begin
          state_d     = IDLE;
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          gnt_idx_d   = 3'd0;
          hcnt_d      = 4'd0;
        end else if (!req[gnt_idx_q]) begin
          // Owner released: its bit is already low, so req is the candidate set.
          if (|req) begin
            do_grant = 1'b1;
            cand     = req;
          end else begin
            state_d     = IDLE;
            gnt_d       = 8'h00;
            gnt_valid_d = 1'b0;
            gnt_idx_d   = 3'd0;
            hcnt_d      = 4'd0;
          end
        end else if (hcnt_q < HOLD_LIMIT) begin
          hcnt_d = hcnt_q + 4'd1;
        end else if (|(req & ~gnt_q)) begin
          do_grant = 1'b1;
          cand     = req & ~gnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        gnt_idx_d   = 3'd0;
        hcnt_d      = 4'd0;
      end
    endcase

    if (do_grant) begin
      win         = pick(cand, ptr_q);
      state_d     = GRANT;
      gnt_d       = 8'b1 << win;
      gnt_valid_d = 1'b1;
      gnt_idx_d   = win;
      ptr_d       = win - 3'd1;
      hcnt_d      = 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd7;
      hcnt_q      <= 4'd0;
      gnt_q       <= 8'h00;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hcnt_q      <= hcnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_arb8 : directed, table-driven bench for the round-robin arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rr_arb8;

  logic       clock;
  logic       reset;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0] req;
    logic       en;
    logic [7:0] gnt;
  } vec_t;

  vec_t vt[16];

  rr_arb8 #(.MAX_HOLD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 0; k < 8; k++)
      if (g[k]) r = 3'(k);
    return r;
  endfunction

  // Structural invariants checked after every edge against the req that decided it.
  task automatic invariants(input logic [7:0] r);
    logic [7:0] g;
    g = gnt;
    check("onehot", 32'(g & (g - 8'd1)), 32'd0);
    check("gnt_vs_req", 32'(g & ~r), 32'd0);
    check("gnt_valid", 32'(gnt_valid), 32'(|g));
    check("gnt_idx", 32'(gnt_idx), 32'(idx_of(g)));
  endtask

  task automatic step(input logic [7:0] r, input logic e, input logic [7:0] exp_g, input string nm);
    @(negedge clock);
    req = r;
    en  = e;
    @(posedge clock);
    #1;
    check(nm, 32'(gnt), 32'(exp_g));
    invariants(r);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = 8'h00;
    en    = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    en      = 1'b0;
    req     = 8'h00;

    vt[0]  = '{8'h00, 1'b1, 8'h00};
    vt[1]  = '{8'h90, 1'b1, 8'h80};
    vt[2]  = '{8'h10, 1'b1, 8'h10};  // release handoff, no idle cycle
    vt[3]  = '{8'h10, 1'b1, 8'h10};
    vt[4]  = '{8'h00, 1'b1, 8'h00};
    vt[5]  = '{8'h21, 1'b1, 8'h01};  // ptr=3 -> search 3..0
    vt[6]  = '{8'h21, 1'b0, 8'h00};
    vt[7]  = '{8'h21, 1'b0, 8'h00};
    vt[8]  = '{8'h21, 1'b1, 8'h20};  // ptr=7 -> bit5 first
    vt[9]  = '{8'h01, 1'b0, 8'h00};  // release and en=0 together
    vt[10] = '{8'h24, 1'b1, 8'h04};  // ptr=4 -> bit2 first
    vt[11] = '{8'h24, 1'b1, 8'h04};
    vt[12] = '{8'h24, 1'b1, 8'h04};
    vt[13] = '{8'h24, 1'b1, 8'h04};
    vt[14] = '{8'h24, 1'b1, 8'h20};  // hold limit reached -> preempt
    vt[15] = '{8'h20, 1'b1, 8'h20};

    // Reset state and first grant after release from reset
    #1;
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_valid", 32'(gnt_valid), 32'd0);
    check("reset_idx", 32'(gnt_idx), 32'd0);
    req = 8'hFF;
    en  = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("first_grant", 32'(gnt), 32'h80);
    invariants(8'hFF);
    step(8'hFF, 1'b1, 8'h80, "hold7_a");
    step(8'hFF, 1'b1, 8'h80, "hold7_b");

    // Asynchronous reset mid-grant, checked before any clock edge
    #3;
    reset = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_valid", 32'(gnt_valid), 32'd0);
    check("async_idx", 32'(gnt_idx), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("regrant_after_reset", 32'(gnt), 32'h80);
    invariants(8'hFF);

    // Table-driven sequence from a fresh reset
    do_reset();
    for (int i = 0; i < 16; i++)
      step(vt[i].req, vt[i].en, vt[i].gnt, $sformatf("vec%0d", i));

    // Rotation under constant full request
    do_reset();
    for (int c = 0; c < 36; c++)
      step(8'hFF, 1'b1, 8'h80 >> ((c / 4) % 8), $sformatf("rot%0d", c));

    // Lone holder is never preempted
    do_reset();
    for (int c = 0; c < 10; c++)
      step(8'h01, 1'b1, 8'h01, $sformatf("lone%0d", c));
    step(8'h00, 1'b1, 8'h00, "lone_release");
    step(8'h00, 1'b1, 8'h00, "lone_idle");

    // Enable drop keeps ptr, next search starts below former owner
    do_reset();
    step(8'h20, 1'b1, 8'h20, "en_owner5");
    step(8'h20, 1'b0, 8'h00, "en_drop");
    step(8'h21, 1'b1, 8'h01, "en_resume");
    check("en_resume_idx", 32'(gnt_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
